// File: rtl/cond_flag_unit_if.sv
// Condition-check request/response handshake between the issue stage and cond_flag_unit.
// The master issues condition fields and consumes pass/fail results; the slave evaluates them.
interface cond_flag_unit_if;
  logic       cond_valid;
  logic [3:0] cond;
  logic       cond_ready;
  logic       pass_valid;
  logic       pass;
  logic       pass_ready;

  modport master (
    output cond_valid, cond, pass_ready,
    input  cond_ready, pass_valid, pass
  );

  modport slave (
    input  cond_valid, cond, pass_ready,
    output cond_ready, pass_valid, pass
  );
endinterface

// File: rtl/cond_flag_unit.sv
// NZCV status register plus ARM condition evaluation with a one-slot registered result.
// Optional macro COND_FWD_EN: evaluate on same-cycle flag writes instead of interlocking.
//
// state | meaning
// EMPTY | no result held; a request can always be accepted
// FULL  | result held on pass/pass_valid until downstream consumes it
module cond_flag_unit (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flag_we,
  input  logic [3:0]       alu_op,
  input  logic             nf_in,
  input  logic             zf_in,
  input  logic             cf_in,
  input  logic             vf_in,
  input  logic             shift_cout,
  cond_flag_unit_if.slave  hs,
  output logic [3:0]       flags
);

  typedef enum logic {EMPTY, FULL} slot_t;

  slot_t      state;
  logic       arith_op;
  logic [3:0] next_flags;
  logic [3:0] eval_flags;
  logic       interlock;
  logic       accept;
  logic       eval_pass;
  logic       n, z, c, v;

  // SUB..RSC are 0010-0111, CMP/CMN are 1010/1011
  always_comb begin
    arith_op = 1'b0;
    case (alu_op[3:1])
      3'b001, 3'b010, 3'b011, 3'b101: arith_op = 1'b1;
      default:                         arith_op = 1'b0;
    endcase
  end

  assign next_flags = arith_op ? {nf_in, zf_in, cf_in, vf_in}
                               : {nf_in, zf_in, shift_cout, flags[0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      flags <= 4'b0000;
    else if (flag_we)
      flags <= next_flags;
  end

`ifdef COND_FWD_EN
  assign eval_flags = flag_we ? next_flags : flags;
  assign interlock  = 1'b0;
`else
  // Holding off requests during a flag write keeps evaluation on registered flags only.
  assign eval_flags = flags;
  assign interlock  = flag_we;
`endif

  assign hs.cond_ready = ((state == EMPTY) || hs.pass_ready) && !interlock;
  assign accept        = hs.cond_valid && hs.cond_ready;
  assign {n, z, c, v}  = eval_flags;

  always_comb begin
    eval_pass = 1'b0;
    case (hs.cond)
      4'b0000: eval_pass = z;
      4'b0001: eval_pass = !z;
      4'b0010: eval_pass = c;
      4'b0011: eval_pass = !c;
      4'b0100: eval_pass = n;
      4'b0101: eval_pass = !n;
      4'b0110: eval_pass = v;
      4'b0111: eval_pass = !v;
      4'b1000: eval_pass = c && !z;
      4'b1001: eval_pass = !c || z;
      4'b1010: eval_pass = (n == v);
      4'b1011: eval_pass = (n != v);
      4'b1100: eval_pass = !z && (n == v);
      4'b1101: eval_pass = z || (n != v);
      4'b1110: eval_pass = 1'b1;
      default: eval_pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= EMPTY;
      hs.pass_valid <= 1'b0;
      hs.pass       <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state         <= FULL;
            hs.pass_valid <= 1'b1;
            hs.pass       <= eval_pass;
          end
        end
        FULL: begin
          // accept here implies pass_ready, so the slot reloads in place
          if (accept) begin
            hs.pass <= eval_pass;
          end else if (hs.pass_ready) begin
            state         <= EMPTY;
            hs.pass_valid <= 1'b0;
          end
        end
        default: begin
          state         <= EMPTY;
          hs.pass_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit: directed literal checks plus randomized traffic
// compared every cycle against a flag/slot reference model.
module tb_cond_flag_unit;

  localparam logic [3:0] OP_AND = 4'b0000, OP_SUB = 4'b0010, OP_RSB = 4'b0011,
                         OP_ADD = 4'b0100, OP_ADC = 4'b0101, OP_SBC = 4'b0110,
                         OP_RSC = 4'b0111, OP_CMP = 4'b1010, OP_CMN = 4'b1011,
                         OP_MOV = 4'b1101;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flag_we = 1'b0;
  logic [3:0] alu_op = 4'b0000;
  logic       nf_in = 1'b0, zf_in = 1'b0, cf_in = 1'b0, vf_in = 1'b0;
  logic       shift_cout = 1'b0;
  logic [3:0] flags;
  logic       started = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  cond_flag_unit_if hs ();

  cond_flag_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flag_we    (flag_we),
    .alu_op     (alu_op),
    .nf_in      (nf_in),
    .zf_in      (zf_in),
    .cf_in      (cf_in),
    .vf_in      (vf_in),
    .shift_cout (shift_cout),
    .hs         (hs.slave),
    .flags      (flags)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic m_n, m_z, m_c, m_v;
  logic m_valid, m_pass;
  logic [3:0] post;
  logic exp_ready;

  function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
    logic fn, fz, fc, fv;
    {fn, fz, fc, fv} = f;
    case (cc)
      4'd0:  return fz;
      4'd1:  return !fz;
      4'd2:  return fc;
      4'd3:  return !fc;
      4'd4:  return fn;
      4'd5:  return !fn;
      4'd6:  return fv;
      4'd7:  return !fv;
      4'd8:  return fc & !fz;
      4'd9:  return !fc | fz;
      4'd10: return fn == fv;
      4'd11: return fn != fv;
      4'd12: return !fz & (fn == fv);
      4'd13: return fz | (fn != fv);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    post = {m_n, m_z, m_c, m_v};
    if (flag_we) begin
      if (alu_op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN})
        post = {nf_in, zf_in, cf_in, vf_in};
      else
        post = {nf_in, zf_in, shift_cout, m_v};
    end
  end

  always_comb begin
    exp_ready = !m_valid || hs.pass_ready;
`ifndef COND_FWD_EN
    if (flag_we) exp_ready = 1'b0;
`endif
  end

  // Both builds must give the result on the newest flags, so the model always uses post.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {m_n, m_z, m_c, m_v} <= 4'b0000;
      m_valid <= 1'b0;
      m_pass  <= 1'b0;
    end else begin
      {m_n, m_z, m_c, m_v} <= post;
      if (hs.cond_valid && exp_ready) begin
        m_valid <= 1'b1;
        m_pass  <= cond_holds(hs.cond, post);
      end else if (m_valid && hs.pass_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started && reset_n) begin
      check("model_flags", flags, {m_n, m_z, m_c, m_v});
      check("model_pass_valid", {3'b0, hs.pass_valid}, {3'b0, m_valid});
      if (m_valid) check("model_pass", {3'b0, hs.pass}, {3'b0, m_pass});
      check("model_cond_ready", {3'b0, hs.cond_ready}, {3'b0, exp_ready});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags_in(input logic [3:0] op, input logic [3:0] nzcv, input logic sc);
    flag_we = 1'b1;
    alu_op  = op;
    {nf_in, zf_in, cf_in, vf_in} = nzcv;
    shift_cout = sc;
  endtask

  initial begin
    hs.cond_valid = 1'b0;
    hs.cond       = 4'b0000;
    hs.pass_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    started = 1'b1;
    #1;
    check("reset_flags", flags, 4'b0000);
    check("reset_pass_valid", {3'b0, hs.pass_valid}, 4'd0);
    check("reset_cond_ready", {3'b0, hs.cond_ready}, 4'd1);

    // AL then NV
    step();
    hs.cond_valid = 1'b1; hs.cond = 4'b1110;
    step();
    check("al_valid", {3'b0, hs.pass_valid}, 4'd1);
    check("al_pass", {3'b0, hs.pass}, 4'd1);
    hs.cond = 4'b1111;
    step();
    check("nv_pass", {3'b0, hs.pass}, 4'd0);
    hs.cond_valid = 1'b0;

    // arithmetic update: CMP with NZCV=0110
    set_flags_in(OP_CMP, 4'b0110, 1'b0);
    step();
    flag_we = 1'b0;
    check("cmp_flags", flags, 4'b0110);
    hs.cond_valid = 1'b1; hs.cond = 4'b0000;
    step();
    check("eq_pass", {3'b0, hs.pass}, 4'd1);
    hs.cond = 4'b1000;
    step();
    check("hi_pass", {3'b0, hs.pass}, 4'd0);
    hs.cond_valid = 1'b0;

    // logical update keeps V
    set_flags_in(OP_ADD, 4'b0001, 1'b0);
    step();
    set_flags_in(OP_MOV, 4'b1000, 1'b1);
    step();
    flag_we = 1'b0;
    check("mov_flags", flags, 4'b1011);
    hs.cond_valid = 1'b1; hs.cond = 4'b1010;
    step();
    check("ge_pass", {3'b0, hs.pass}, 4'd1);
    hs.cond_valid = 1'b0;

    // backpressure with flag write during hold
    set_flags_in(OP_CMP, 4'b0100, 1'b0);
    step();
    flag_we = 1'b0;
    hs.cond_valid = 1'b1; hs.cond = 4'b0000; hs.pass_ready = 1'b0;
    step();
    hs.cond = 4'b0001;
    #1;
    check("bp_ready0", {3'b0, hs.cond_ready}, 4'd0);
    set_flags_in(OP_CMP, 4'b0000, 1'b0);
    step();
    flag_we = 1'b0;
    check("bp_hold1", {3'b0, hs.pass}, 4'd1);
    check("bp_valid", {3'b0, hs.pass_valid}, 4'd1);
    step();
    check("bp_hold2", {3'b0, hs.pass}, 4'd1);
    check("bp_ready1", {3'b0, hs.cond_ready}, 4'd0);
    hs.pass_ready = 1'b1; hs.cond = 4'b0000;
    #1;
    check("bp_release_ready", {3'b0, hs.cond_ready}, 4'd1);
    step();
    check("bp_reload_valid", {3'b0, hs.pass_valid}, 4'd1);
    check("bp_reload_pass", {3'b0, hs.pass}, 4'd0);
    hs.cond_valid = 1'b0;
    step();
    check("bp_drained", {3'b0, hs.pass_valid}, 4'd0);

    // coincident flag write and EQ request
    set_flags_in(OP_ADD, 4'b0100, 1'b0);
    hs.cond_valid = 1'b1; hs.cond = 4'b0000;
    #1;
`ifdef COND_FWD_EN
    check("co_ready", {3'b0, hs.cond_ready}, 4'd1);
    step();
    flag_we = 1'b0; hs.cond_valid = 1'b0;
    check("co_valid", {3'b0, hs.pass_valid}, 4'd1);
    check("co_pass", {3'b0, hs.pass}, 4'd1);
`else
    check("co_ready", {3'b0, hs.cond_ready}, 4'd0);
    step();
    flag_we = 1'b0;
    check("co_not_yet", {3'b0, hs.pass_valid}, 4'd0);
    #1;
    check("co_ready_next", {3'b0, hs.cond_ready}, 4'd1);
    step();
    hs.cond_valid = 1'b0;
    check("co_valid", {3'b0, hs.pass_valid}, 4'd1);
    check("co_pass", {3'b0, hs.pass}, 4'd1);
`endif
    step();

    // async reset while FULL
    hs.cond_valid = 1'b1; hs.cond = 4'b1110; hs.pass_ready = 1'b0;
    step();
    hs.cond_valid = 1'b0;
    check("ar_full", {3'b0, hs.pass_valid}, 4'd1);
    #1 reset_n = 1'b0;
    #1;
    check("ar_valid", {3'b0, hs.pass_valid}, 4'd0);
    check("ar_flags", flags, 4'b0000);
    #4 reset_n = 1'b1;
    hs.pass_ready = 1'b1;
    step();
    check("ar_after_valid", {3'b0, hs.pass_valid}, 4'd0);
    check("ar_after_flags", flags, 4'b0000);

    // randomized traffic; the negedge compare process does the checking
    for (int i = 0; i < 3000; i++) begin
      flag_we       = ($urandom_range(0, 2) == 0);
      alu_op        = 4'($urandom_range(0, 15));
      {nf_in, zf_in, cf_in, vf_in} = 4'($urandom_range(0, 15));
      shift_cout    = 1'($urandom_range(0, 1));
      hs.cond_valid = ($urandom_range(0, 3) != 0);
      hs.cond       = 4'($urandom_range(0, 15));
      hs.pass_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    flag_we = 1'b0;
    hs.cond_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_flag_unit.md
# cond_flag_unit

Status-register and condition-evaluation stage that consumes the NZCV flags produced by the ALU. It holds the architectural NZCV flags and applies flag writes according to each operation's class. It evaluates the 4-bit ARM condition field of each issued instruction against those flags and returns a registered pass/fail result over a valid/ready handshake. It sits between the ALU flag outputs and the execute/writeback enable logic.

## Interface
- No parameters; all widths are fixed by the ISA.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flag_we`  in  1  commit ALU flags this cycle (S-bit instruction retiring).
- `alu_op`  in  4  ALU opcode of the committing instruction, in the team encoding: AND=0000, EOR=0001, SUB=0010, RSB=0011, ADD=0100, ADC=0101, SBC=0110, RSC=0111, TST=1000, TEQ=1001, CMP=1010, CMN=1011, OR=1100, MOV=1101, BIC=1110, MVN=1111.
- `nf_in`, `zf_in`, `cf_in`, `vf_in`  in  1 each  flags from the ALU.
- `shift_cout`  in  1  barrel-shifter carry-out; used as C for logical ops.
- `cond_valid`  in  1  condition-check request valid.
- `cond`  in  4  condition field, bits [31:28] of the instruction.
- `cond_ready`  out  1  request accepted when `cond_valid && cond_ready`.
- `pass_valid`  out  1  result valid.
- `pass`  out  1  1 = execute, 0 = squash.
- `pass_ready`  in  1  downstream consumes the result when `pass_valid && pass_ready`.
- `flags`  out  4  current {N,Z,C,V}; also drives the ALU `Cin`.

## Operation
- **Arithmetic class** (SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN): on `flag_we`, all four flags load from `nf_in`, `zf_in`, `cf_in`, `vf_in`.
- **Logical class** (all other opcodes): on `flag_we`, N and Z load from the ALU, C loads from `shift_cout`, and V is unchanged.
- **Condition decode:**
  - EQ 0000: Z.
  - NE 0001: !Z.
  - CS 0010: C.
  - CC 0011: !C.
  - MI 0100: N.
  - PL 0101: !N.
  - VS 0110: V.
  - VC 0111: !V.
  - HI 1000: C&!Z.
  - LS 1001: !C|Z.
  - GE 1010: N==V.
  - LT 1011: N!=V.
  - GT 1100: !Z&(N==V).
  - LE 1101: Z|(N!=V).
  - AL 1110: 1.
  - NV 1111: 0.
- **Result register:** a single output slot with two states.
  - EMPTY→FULL on accept.
  - FULL→EMPTY on consume with no new accept.
  - FULL→FULL on simultaneous consume and accept; the slot reloads.
- **Ready logic:** `cond_ready` = (EMPTY or `pass_ready`) and no flag interlock (see Configuration). `cond_ready` is combinational from `pass_ready`.
- **Held result:** while FULL and `pass_ready`=0, `pass` is held stable. Later flag writes never alter a held result.
- **Newest-flags rule:** evaluation always reflects every flag write committed in or before the accept cycle.

## Timing
- **Reset values:** flags=0000, slot EMPTY, `pass_valid`=0, `pass`=0, `cond_ready`=1 (without COND_FWD_EN it is still gated by `flag_we`).
- **Flag latency:** `flags` reflects a write one cycle after the `flag_we` edge.
- **Result latency:** 1 cycle. `pass_valid` and `pass` are registered and appear the cycle after the accept.
- **Throughput:** one request per cycle while `pass_ready`=1.
- **Reset mid-operation:** deasserting `reset_n` clears flags and the slot immediately. Any pending result is dropped and no handshake completes.

## Configuration
- **`COND_FWD_EN` defined:**
  - When `flag_we` and an accept coincide, the condition is evaluated on the post-update flags, computed combinationally with the class rules above.
  - `cond_ready` is never gated by `flag_we`.
- **`COND_FWD_EN` undefined:**
  - `cond_ready` is forced to 0 in any cycle with `flag_we`=1 (one-cycle interlock).
  - Evaluation uses only the registered `flags`.
  - Throughput drops, but results are identical to the forwarded build.

## Test plan
- **Reset and defaults:** reset, then request `cond`=1110 → next cycle `pass_valid`=1, `pass`=1. Request `cond`=1111 → `pass`=0. `flags`=0000.
- **Arithmetic update:** `flag_we` with `alu_op`=CMP and NZCV=0110, then `cond`=0000 (EQ) → `pass`=1. `cond`=1000 (HI) → `pass`=0.
- **Logical update:** flags=0001, then `flag_we` with `alu_op`=MOV, NZ=10, `shift_cout`=1, `vf_in`=0 → flags=1011. `cond`=1010 (GE) → `pass`=1.
- **Backpressure:**
  - Accept EQ with Z=1 while `pass_ready`=0 for 3 cycles, with a flag write setting Z=0 in between → `pass` stays 1 and `cond_ready`=0.
  - Release `pass_ready` → consumed, and a same-cycle new request is accepted.
- **Coincident flag write and request:** `flag_we` (ADD, Z=1) in the same cycle as `cond_valid`, `cond`=0000.
  - With COND_FWD_EN: accepted that cycle, `pass`=1.
  - Without COND_FWD_EN: `cond_ready`=0, accepted next cycle, `pass`=1.
- **Async reset mid-flight:** pulse `reset_n` low for half a cycle while FULL → `pass_valid`=0 and flags=0000 immediately, with no handshake.
